// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running h/v counters, sync/de decode,
// a pix_en-gated alignment delay line and line/frame start pulses.
module vga_timing_gen #(
    parameter int H_ACTIVE_PIXEL_COUNT = 1280,
    parameter int H_FRONT_PORCH        = 110,
    parameter int H_SYNC_WIDTH         = 40,
    parameter int H_BACK_PORCH         = 220,
    parameter int V_ACTIVE_LINE_COUNT  = 720,
    parameter int V_FRONT_PORCH        = 5,
    parameter int V_SYNC_WIDTH         = 5,
    parameter int V_BACK_PORCH         = 20,
    parameter bit H_SYNC_POL           = 1'b1,
    parameter bit V_SYNC_POL           = 1'b1,
    parameter int PIPE_DELAY           = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    output logic [11:0] h_counter,
    output logic [11:0] v_counter,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        line_start,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE_PIXEL_COUNT + H_FRONT_PORCH
                           + H_SYNC_WIDTH + H_BACK_PORCH;
    localparam int V_TOTAL = V_ACTIVE_LINE_COUNT + V_FRONT_PORCH
                           + V_SYNC_WIDTH + V_BACK_PORCH;
    localparam int HS_START = H_ACTIVE_PIXEL_COUNT + H_FRONT_PORCH;
    localparam int HS_END   = HS_START + H_SYNC_WIDTH;
    localparam int VS_START = V_ACTIVE_LINE_COUNT + V_FRONT_PORCH;
    localparam int VS_END   = VS_START + V_SYNC_WIDTH;
    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

    if (H_TOTAL > 4096) begin : g_h_total_chk
        $error("vga_timing_gen: H_TOTAL exceeds 4096");
    end
    if (V_TOTAL > 4096) begin : g_v_total_chk
        $error("vga_timing_gen: V_TOTAL exceeds 4096");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_pipe_chk
        $error("vga_timing_gen: PIPE_DELAY must be 0..7");
    end

    logic       h_wrap;
    logic       v_wrap;
    logic [2:0] raw;
    logic [2:0] dly;
    int         h_int;
    int         v_int;

    assign h_wrap = (h_counter == H_LAST);
    assign v_wrap = (v_counter == V_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_counter   <= '0;
            v_counter   <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            // Pulses re-evaluate every clk so they last exactly one cycle
            line_start  <= pix_en && h_wrap;
            frame_start <= pix_en && h_wrap && v_wrap;
            if (pix_en) begin
                h_counter <= h_wrap ? 12'd0 : h_counter + 12'd1;
                if (h_wrap) begin
                    v_counter <= v_wrap ? 12'd0 : v_counter + 12'd1;
                end
            end
        end
    end

    always_comb begin
        h_int  = int'(h_counter);
        v_int  = int'(v_counter);
        raw    = 3'b000;
        raw[2] = (h_int >= HS_START) && (h_int < HS_END);
        raw[1] = (v_int >= VS_START) && (v_int < VS_END);
        raw[0] = (h_int < H_ACTIVE_PIXEL_COUNT)
              && (v_int < V_ACTIVE_LINE_COUNT);
    end

    if (PIPE_DELAY == 0) begin : g_no_pipe
        assign dly = raw;
    end else begin : g_pipe
        logic [2:0] stage [PIPE_DELAY];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < PIPE_DELAY; i++) begin
                    stage[i] <= 3'b000;
                end
            end else if (pix_en) begin
                stage[0] <= raw;
                for (int i = 1; i < PIPE_DELAY; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign dly = stage[PIPE_DELAY-1];
    end

    // Cleared delay regs read as inactive, whatever the polarity
    assign hsync = H_SYNC_POL ? dly[2] : ~dly[2];
    assign vsync = V_SYNC_POL ? dly[1] : ~dly[1];
    assign de    = dly[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default mode plus small modes
// covering frame wrap, throttling, polarity and delay depth.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pix_en = 1'b1;

    logic [11:0] d_h, d_v, s_h, s_v, a_h, a_v, b_h, b_v;
    logic d_hs, d_vs, d_de, d_ls, d_fs;
    logic s_hs, s_vs, s_de, s_ls, s_fs;
    logic a_hs, a_vs, a_de, a_ls, a_fs;
    logic b_hs, b_vs, b_de, b_ls, b_fs;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_def (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .h_counter(d_h), .v_counter(d_v),
        .hsync(d_hs), .vsync(d_vs), .de(d_de),
        .line_start(d_ls), .frame_start(d_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE_PIXEL_COUNT(8), .H_FRONT_PORCH(2),
        .H_SYNC_WIDTH(2), .H_BACK_PORCH(2),
        .V_ACTIVE_LINE_COUNT(4), .V_FRONT_PORCH(1),
        .V_SYNC_WIDTH(1), .V_BACK_PORCH(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .PIPE_DELAY(1)
    ) u_small (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .h_counter(s_h), .v_counter(s_v),
        .hsync(s_hs), .vsync(s_vs), .de(s_de),
        .line_start(s_ls), .frame_start(s_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE_PIXEL_COUNT(8), .H_FRONT_PORCH(2),
        .H_SYNC_WIDTH(2), .H_BACK_PORCH(2),
        .V_ACTIVE_LINE_COUNT(4), .V_FRONT_PORCH(1),
        .V_SYNC_WIDTH(1), .V_BACK_PORCH(1),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .PIPE_DELAY(0)
    ) u_neg0 (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .h_counter(a_h), .v_counter(a_v),
        .hsync(a_hs), .vsync(a_vs), .de(a_de),
        .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE_PIXEL_COUNT(8), .H_FRONT_PORCH(2),
        .H_SYNC_WIDTH(2), .H_BACK_PORCH(2),
        .V_ACTIVE_LINE_COUNT(4), .V_FRONT_PORCH(1),
        .V_SYNC_WIDTH(1), .V_BACK_PORCH(1),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .PIPE_DELAY(3)
    ) u_neg3 (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .h_counter(b_h), .v_counter(b_v),
        .hsync(b_hs), .vsync(b_vs), .de(b_de),
        .line_start(b_ls), .frame_start(b_fs)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Step the small instances until they sit at (th,tv); with thr set
    // every enabled edge is preceded by one pix_en=0 cycle.
    task automatic run_to(input int th, input int tv, input bit thr,
                          output int cyc);
        bit ok;
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 400; i++) begin
            if (thr) begin
                pix_en = 1'b0;
                tick();
                cyc++;
                pix_en = 1'b1;
            end
            tick();
            cyc++;
            if (int'(s_h) == th && int'(s_v) == tv) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("reach_%0d_%0d", th, tv), 32'(ok), 32'd1);
    endtask

    initial begin
        int  cyc;
        int  ls_cnt, ls_k0, ls_gap;
        int  de_rise_h, de_len, de_k;
        int  hs_rise_h, hs_len, hs_k;
        logic de_p, hs_p;
        bit  found;

        // Reset held with pix_en active
        rst    = 1'b0;
        pix_en = 1'b1;
        repeat (10) tick();
        chk("rst_h", 32'(d_h), 0);
        chk("rst_v", 32'(d_v), 0);
        chk("rst_hsync", 32'(d_hs), 0);
        chk("rst_vsync", 32'(d_vs), 0);
        chk("rst_de", 32'(d_de), 0);
        chk("rst_ls", 32'(d_ls), 0);
        chk("rst_fs", 32'(d_fs), 0);
        chk("rst_neg0_hs", 32'(a_hs), 1);
        chk("rst_neg3_vs", 32'(b_vs), 1);

        rst = 1'b1;
        repeat (5) tick();
        chk("rel_h", 32'(d_h), 5);
        chk("rel_v", 32'(d_v), 0);
        chk("rel_de", 32'(d_de), 1);
        chk("rel_ls", 32'(d_ls), 0);

        // Two default-mode lines, measuring edges and pulse spacing
        ls_cnt = 0; ls_k0 = 0; ls_gap = 0;
        de_rise_h = -1; de_len = -1; de_k = -1;
        hs_rise_h = -1; hs_len = -1; hs_k = -1;
        de_p = d_de;
        hs_p = d_hs;
        for (int k = 1; k <= 3300; k++) begin
            tick();
            if (d_ls) begin
                ls_cnt++;
                if (ls_cnt == 1) ls_k0 = k;
                if (ls_cnt == 2) ls_gap = k - ls_k0;
            end
            if (d_de && !de_p && de_k < 0) begin
                de_k = k;
                de_rise_h = int'(d_h);
            end
            if (!d_de && de_p && de_k >= 0 && de_len < 0)
                de_len = k - de_k;
            if (d_hs && !hs_p && hs_k < 0) begin
                hs_k = k;
                hs_rise_h = int'(d_h);
            end
            if (!d_hs && hs_p && hs_k >= 0 && hs_len < 0)
                hs_len = k - hs_k;
            de_p = d_de;
            hs_p = d_hs;
        end
        chk("de_rise_h", 32'(de_rise_h), 1);
        chk("de_len", 32'(de_len), 1280);
        chk("hs_rise_h", 32'(hs_rise_h), 1391);
        chk("hs_len", 32'(hs_len), 40);
        chk("ls_count", 32'(ls_cnt), 2);
        chk("ls_gap", 32'(ls_gap), 1650);
        chk("line_v", 32'(d_v), 2);
        chk("line_h", 32'(d_h), 5);

        // Async reset in the middle of hsync
        found = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            tick();
            if (d_h == 12'd1400) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_h1400", 32'(found), 1);
        chk("mid_hsync", 32'(d_hs), 1);
        chk("mid_de", 32'(d_de), 0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_h", 32'(d_h), 0);
        chk("arst_v", 32'(d_v), 0);
        chk("arst_hsync", 32'(d_hs), 0);
        chk("arst_neg0_hs", 32'(a_hs), 1);
        repeat (2) tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("restart_h", 32'(d_h), 3);
        chk("restart_v", 32'(d_v), 0);
        chk("restart_small_h", 32'(s_h), 3);

        // Small modes: hsync position for delays 1, 0 and 3
        run_to(10, 0, 1'b0, cyc);
        chk("s10_hs", 32'(s_hs), 0);
        chk("n0_10_hs", 32'(a_hs), 0);
        chk("n3_10_hs", 32'(b_hs), 1);
        run_to(11, 0, 1'b0, cyc);
        chk("s11_hs", 32'(s_hs), 1);
        run_to(13, 0, 1'b0, cyc);
        chk("s13_hs", 32'(s_hs), 0);
        chk("n0_13_hs", 32'(a_hs), 1);
        chk("n3_13_hs", 32'(b_hs), 0);
        run_to(0, 1, 1'b0, cyc);
        chk("n3_0_hs", 32'(b_hs), 0);
        chk("s_ls_line1", 32'(s_ls), 1);
        chk("s_fs_line1", 32'(s_fs), 0);
        chk("s_de_0_1", 32'(s_de), 0);
        chk("n0_de_0_1", 32'(a_de), 1);
        run_to(1, 1, 1'b0, cyc);
        chk("n3_1_hs", 32'(b_hs), 1);
        chk("s_de_1_1", 32'(s_de), 1);
        chk("s_ls_off", 32'(s_ls), 0);

        // vsync covers only line 5, shifted by the delay depth
        run_to(0, 5, 1'b0, cyc);
        chk("s_vs_0_5", 32'(s_vs), 0);
        chk("n0_vs_0_5", 32'(a_vs), 0);
        run_to(1, 5, 1'b0, cyc);
        chk("s_vs_1_5", 32'(s_vs), 1);
        run_to(0, 6, 1'b0, cyc);
        chk("s_vs_0_6", 32'(s_vs), 1);
        chk("n0_vs_0_6", 32'(a_vs), 1);
        run_to(1, 6, 1'b0, cyc);
        chk("s_vs_1_6", 32'(s_vs), 0);
        run_to(2, 6, 1'b0, cyc);
        chk("n3_vs_2_6", 32'(b_vs), 0);
        run_to(3, 6, 1'b0, cyc);
        chk("n3_vs_3_6", 32'(b_vs), 1);

        // Frame wrap
        run_to(13, 6, 1'b0, cyc);
        chk("fs_pre", 32'(s_fs), 0);
        tick();
        chk("wrap_h", 32'(s_h), 0);
        chk("wrap_v", 32'(s_v), 0);
        chk("fs_pulse", 32'(s_fs), 1);
        chk("ls_pulse", 32'(s_ls), 1);
        tick();
        chk("fs_clear", 32'(s_fs), 0);
        chk("ls_clear", 32'(s_ls), 0);

        // Throttled pix_en: line period doubles, pulses stay one clk
        run_to(1, 1, 1'b1, cyc);
        chk("thr_line_cyc", 32'(cyc), 28);
        run_to(11, 1, 1'b1, cyc);
        chk("thr_s11_hs", 32'(s_hs), 1);
        pix_en = 1'b0;
        tick();
        chk("thr_hold_h", 32'(s_h), 11);
        chk("thr_hold_hs", 32'(s_hs), 1);
        pix_en = 1'b1;
        run_to(13, 1, 1'b1, cyc);
        chk("thr_s13_hs", 32'(s_hs), 0);
        chk("thr_n3_13_hs", 32'(b_hs), 0);
        run_to(0, 2, 1'b1, cyc);
        chk("thr_ls", 32'(s_ls), 1);
        chk("thr_de_0", 32'(s_de), 0);
        pix_en = 1'b0;
        tick();
        chk("thr_ls_width", 32'(s_ls), 0);
        chk("thr_hold_h0", 32'(s_h), 0);
        chk("thr_hold_de", 32'(s_de), 0);
        pix_en = 1'b1;
        tick();
        chk("thr_de_1", 32'(s_de), 1);
        chk("thr_h1", 32'(s_h), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
